ifu_axi_prefetch: RTL and testbench
===================================

// Module: ifu_axi_prefetch
// PURPOSE
//   Parametrised successor to the single-beat IFU fetch path: AXI4 read-only instruction
//   fetch master with configurable INCR bursts, a prefetch FIFO and PC redirect (branch/flush).
//   Sits between the core front-end (decode consumes inst_*) and the instruction memory AXI slave.
//   Write channels are absent; this master never writes.
// PARAMETERS
//   INST_MEM_BASE_ADDR  32'h40000000  PC fetched first after reset
//   BURST_LEN           4             beats per AR burst; power of 2, 1..16
//   FIFO_DEPTH          8             prefetch entries; power of 2, >= BURST_LEN
//   AXI_ID              0             constant arid value
// PORTS
//   clk               in   1    clock
//   rst               in   1    synchronous reset, active-high
//   enable            in   1    1 = allow new bursts
//   redirect_valid    in   1    flush pipeline, restart fetch at redirect_pc
//   redirect_pc       in   32   new PC; bits[1:0] ignored
//   inst_valid        out  1    FIFO head valid
//   inst_ready        in   1    consumer accepts head
//   inst_data         out  32   instruction word
//   inst_pc           out  32   PC of inst_data
//   inst_err          out  1    rresp != OKAY for this beat
//   ifu_axi_ar*       out  -    arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion/arvalid, `AXI_* widths
//   ifu_axi_arready   in   1
//   ifu_axi_r*        in   -    rid/rdata/rresp/rlast/rvalid, `AXI_* widths (`AXI_DATA_WIDTH = 32)
//   ifu_axi_rready    out  1
// BEHAVIOUR
//   Reset: all outputs 0 except araddr = INST_MEM_BASE_ADDR; fetch_pc = INST_MEM_BASE_ADDR; FIFO empty; state IDLE.
//   Constants: arlen = BURST_LEN-1, arsize = 3'b010, arburst = INCR, arlock/cache/prot/qos/region = 0.
//   FSM IDLE -> ADDR when enable & credits >= BURST_LEN; credits = FIFO_DEPTH - occupancy, beats in flight counted.
//     araddr = fetch_pc & ~(BURST_LEN*4-1) (aligned; never crosses 4 KB). arvalid is registered: first AR 1 cycle after rst drops with enable=1.
//   ADDR: arvalid, araddr stable until arready; on handshake -> DATA.
//   DATA: rready = 1; each beat with addr >= fetch_pc is pushed {err,pc,data}; beats below fetch_pc (after unaligned redirect) dropped.
//     On rlast -> IDLE, fetch_pc = aligned base + BURST_LEN*4 (32-bit wrap allowed).
//   Redirect (any state): FIFO flushed same cycle; fetch_pc <= redirect_pc & ~3.
//     IDLE: next AR uses new PC. ADDR: AR held until handshake (AXI stability), then DRAIN.
//     DATA: -> DRAIN. DRAIN: rready = 1, beats discarded; on rlast -> IDLE. Redirect in DRAIN only updates fetch_pc.
//   Simultaneous redirect and R beat: beat discarded; redirect and inst pop: pop ignored (FIFO flushed).
//   Push/pop same cycle: occupancy unchanged. FIFO never overflows (credit check); rready never stalls R.
//   enable low: current burst completes, no new AR issued; FIFO still drains to consumer.
//   rid ignored (single outstanding burst). inst_valid = !empty; no combinational path inst_ready -> inst_valid.
//   Reset mid-burst: state, FIFO, arvalid, rready cleared next edge; interconnect is reset together.
// STRUCTURE
//   ifu_pkg: AXI burst/size/resp encodings, FSM state enum (IDLE/ADDR/DATA/DRAIN), default base address.
//   Sub-module ifu_prefetch_fifo: synchronous FIFO, width 65, depth FIFO_DEPTH, flush input, occupancy output.
//   Top: FSM, fetch_pc/beat address counter, credit logic, AR/R channel drive.
// TESTING
//   Reset, enable=1, slave zero-wait -> AR araddr=0x40000000 arlen=3; inst_pc 0x40000000..0x4000000C in order.
//   inst_ready=0 for 50 cycles, DEPTH=8, BURST_LEN=4 -> exactly 2 bursts issued, then arvalid stays 0 until pops.
//   Redirect to 0x40000108 during DATA beat 1 -> rest drained, next araddr=0x40000100, first inst_pc=0x40000108.
//   Redirect while arvalid=1, arready=0 for 5 cycles -> araddr unchanged until handshake, burst fully discarded.
//   rresp=SLVERR on beat 2 -> inst_err=1 only with inst_pc=base+8.
//   Fetch from 0xFFFFFFF0, BURST_LEN=4 -> next araddr wraps to 0x00000000; random arready/rvalid stall scoreboard matches.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared encodings for the AXI instruction fetch unit.
// AXI field widths, burst/size/resp codes, FSM states, FIFO entry layout.
package ifu_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [31:0] IFU_DEF_BASE = 32'h4000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } ifu_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] data;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy output.
// Ports: clk, rst, i_flush, i_push/i_data, i_pop, o_data, o_empty, o_count.
module ifu_prefetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_cnt == '0);
  assign w_wr    = i_push & ~i_flush &
                   (r_cnt != CW'(DEPTH));
  assign w_rd    = i_pop & ~i_flush & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst | i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/ifu_axi_prefetch.sv
// AXI4 read-only instruction fetch master: INCR bursts into a prefetch FIFO.
// Ports: clk/rst, enable, redirect_*, inst_* to decode, ifu_axi_ar*/r* to memory.
module ifu_axi_prefetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] INST_MEM_BASE_ADDR = IFU_DEF_BASE,
  parameter int          BURST_LEN          = 4,
  parameter int          FIFO_DEPTH         = 8,
  parameter int          AXI_ID             = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst_data,
  output logic [31:0]               inst_pc,
  output logic                      inst_err,
  output logic [AXI_ID_WIDTH-1:0]   ifu_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] ifu_axi_araddr,
  output logic [7:0]                ifu_axi_arlen,
  output logic [2:0]                ifu_axi_arsize,
  output logic [1:0]                ifu_axi_arburst,
  output logic                      ifu_axi_arlock,
  output logic [3:0]                ifu_axi_arcache,
  output logic [2:0]                ifu_axi_arprot,
  output logic [3:0]                ifu_axi_arqos,
  output logic [3:0]                ifu_axi_arregion,
  output logic                      ifu_axi_arvalid,
  input  logic                      ifu_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   ifu_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] ifu_axi_rdata,
  input  logic [1:0]                ifu_axi_rresp,
  input  logic                      ifu_axi_rlast,
  input  logic                      ifu_axi_rvalid,
  output logic                      ifu_axi_rready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] ALIGN_MASK  = ~(BURST_BYTES - 32'd1);
  localparam logic [CW-1:0] OCC_MAX   = CW'(FIFO_DEPTH - BURST_LEN);

  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic        r_kill;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_araddr;
  logic [31:0] r_baddr;

  logic          w_ar_hs;
  logic          w_beat;
  logic          w_last;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW-1:0] w_count;
  ifu_entry_t    w_in;
  ifu_entry_t    w_head;
  ifu_entry_t    w_out;
  logic          w_unused_rid;

  assign w_unused_rid = ^ifu_axi_rid;

  assign w_ar_hs = ifu_axi_arvalid & ifu_axi_arready;
  assign w_beat  = ifu_axi_rready & ifu_axi_rvalid;
  assign w_last  = w_beat & ifu_axi_rlast;

  // Beats below fetch_pc come from the aligned head of a burst
  // after an unaligned redirect and are not part of the stream.
  assign w_push = (r_state == S_DATA) & w_beat & ~redirect_valid &
                  (r_baddr >= r_fetch_pc);
  assign w_pop  = inst_valid & inst_ready;

  assign w_in.err  = (ifu_axi_rresp != AXI_RESP_OKAY);
  assign w_in.pc   = r_baddr;
  assign w_in.data = ifu_axi_rdata;

  // Only one burst is ever outstanding, so in IDLE nothing is in
  // flight and the credit check reduces to FIFO occupancy.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (enable & ~redirect_valid & (w_count <= OCC_MAX))
          w_state_nxt = S_ADDR;
      S_ADDR:
        if (w_ar_hs)
          w_state_nxt = (r_kill | redirect_valid) ? S_DRAIN : S_DATA;
      S_DATA:
        if (w_last)
          w_state_nxt = S_IDLE;
        else if (redirect_valid)
          w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (w_last)
          w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_kill     <= 1'b0;
      r_fetch_pc <= INST_MEM_BASE_ADDR;
      r_araddr   <= INST_MEM_BASE_ADDR;
      r_baddr    <= INST_MEM_BASE_ADDR;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_ADDR)
        r_araddr <= r_fetch_pc & ALIGN_MASK;
      if (w_ar_hs)
        r_baddr <= r_araddr;
      else if (w_beat)
        r_baddr <= r_baddr + 32'd4;
      // A redirect while AR is pending cannot retract the request;
      // remember to throw the whole burst away.
      if (w_ar_hs)
        r_kill <= 1'b0;
      else if (r_state == S_ADDR && redirect_valid)
        r_kill <= 1'b1;
      if (redirect_valid)
        r_fetch_pc <= redirect_pc & ~32'd3;
      else if (r_state == S_DATA && w_last)
        r_fetch_pc <= r_araddr + BURST_BYTES;
    end
  end

  ifu_prefetch_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_out      = w_empty ? '0 : w_head;
  assign inst_valid = ~w_empty;
  assign inst_data  = w_out.data;
  assign inst_pc    = w_out.pc;
  assign inst_err   = w_out.err;

  assign ifu_axi_arid     = AXI_ID_WIDTH'(AXI_ID);
  assign ifu_axi_araddr   = r_araddr;
  assign ifu_axi_arlen    = 8'(BURST_LEN - 1);
  assign ifu_axi_arsize   = AXI_SIZE_4B;
  assign ifu_axi_arburst  = AXI_BURST_INCR;
  assign ifu_axi_arlock   = 1'b0;
  assign ifu_axi_arcache  = 4'd0;
  assign ifu_axi_arprot   = 3'd0;
  assign ifu_axi_arqos    = 4'd0;
  assign ifu_axi_arregion = 4'd0;
  assign ifu_axi_arvalid  = (r_state == S_ADDR);
  assign ifu_axi_rready   = (r_state == S_DATA) |
                            (r_state == S_DRAIN);

endmodule

// File: tb/tb_ifu_axi_prefetch.sv
// Bench for ifu_axi_prefetch: AXI slave model plus instruction scoreboard.
// Tasks cover reset, bursts, backpressure, redirects, errors and wrap.
module tb_ifu_axi_prefetch;
  import ifu_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic [AXI_ID_WIDTH-1:0] arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [AXI_ID_WIDTH-1:0] rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  ifu_axi_prefetch dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_err         (inst_err),
    .ifu_axi_arid     (arid),
    .ifu_axi_araddr   (araddr),
    .ifu_axi_arlen    (arlen),
    .ifu_axi_arsize   (arsize),
    .ifu_axi_arburst  (arburst),
    .ifu_axi_arlock   (arlock),
    .ifu_axi_arcache  (arcache),
    .ifu_axi_arprot   (arprot),
    .ifu_axi_arqos    (arqos),
    .ifu_axi_arregion (arregion),
    .ifu_axi_arvalid  (arvalid),
    .ifu_axi_arready  (arready),
    .ifu_axi_rid      (rid),
    .ifu_axi_rdata    (rdata),
    .ifu_axi_rresp    (rresp),
    .ifu_axi_rlast    (rlast),
    .ifu_axi_rvalid   (rvalid),
    .ifu_axi_rready   (rready)
  );

  int vectors = 0;
  int miscompares = 0;
  int ar_stall = 0;
  int r_stall = 0;
  int rdy_pct = 100;
  bit ar_block = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  logic [64:0] sb[$];
  logic [31:0] ar_log[$];
  logic [31:0] bursts[$];

  bit          s_act = 1'b0;
  int          s_beat = 0;
  logic [31:0] s_addr = '0;
  bit          n_ar_hs = 1'b0;
  bit          n_r_hs = 1'b0;
  logic [31:0] n_araddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // negedge: record handshakes and check popped instructions
  initial forever begin
    logic [64:0] got;
    logic [64:0] exp;
    @(negedge clk);
    n_ar_hs  = !rst && arvalid && arready;
    n_araddr = araddr;
    n_r_hs   = !rst && rvalid && rready;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      got = {inst_err, inst_pc, inst_data};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_extra got=%h want=none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL sb_inst got=%h want=%h", got, exp);
        end
      end
    end
  end

  // AXI slave model, drives after each rising edge
  initial forever begin
    logic [31:0] a;
    @(posedge clk);
    #1;
    if (rst) begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata   = '0;
      rresp   = AXI_RESP_OKAY;
      s_act   = 1'b0;
      s_beat  = 0;
      bursts.delete();
      ar_log.delete();
    end else begin
      if (n_ar_hs) begin
        bursts.push_back(n_araddr);
        ar_log.push_back(n_araddr);
      end
      if (n_r_hs) begin
        if (rlast) s_act = 1'b0;
        else s_beat++;
      end
      if (!s_act && bursts.size() > 0) begin
        s_addr = bursts.pop_front();
        s_beat = 0;
        s_act  = 1'b1;
      end
      if (!(rvalid && !n_r_hs)) begin
        if (s_act && $urandom_range(0, 99) >= r_stall) begin
          a      = s_addr + 32'(4 * s_beat);
          rvalid = 1'b1;
          rdata  = mem_word(a);
          rresp  = (a == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rlast  = (s_beat == BL - 1);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
      arready = !ar_block && ($urandom_range(0, 99) >= ar_stall);
    end
  end

  // consumer: only takes instructions the scoreboard expects
  initial forever begin
    @(posedge clk);
    #2;
    inst_ready = !rst && sb.size() > 0 &&
                 ($urandom_range(0, 99) < rdy_pct);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input bit en);
    rst = 1'b1;
    enable = en;
    redirect_valid = 1'b0;
    sb.delete();
    tick(3);
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      sb.push_back({pc == err_addr, pc, mem_word(pc)});
    end
  endtask

  task automatic wait_drain(output bit ok);
    int c = 0;
    while (sb.size() > 0 && c < 3000) begin
      tick();
      c++;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    ar_block = 1'b1;
    rst = 1'b1;
    enable = 1'b1;
    tick(3);
    vectors++;
    if (arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_arvalid got=%0b want=0", arvalid);
    end
    vectors++;
    if (rready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rready got=%0b want=0", rready);
    end
    vectors++;
    if (inst_valid !== 1'b0 || inst_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_inst got=%0b/%h want=0/0", inst_valid, inst_pc);
    end
    vectors++;
    if (araddr !== BASE) begin
      miscompares++;
      $display("FAIL rst_araddr got=%h want=%h", araddr, BASE);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (arvalid !== 1'b1 || araddr !== BASE) begin
      miscompares++;
      $display("FAIL first_ar got=%0b/%h want=1/%h", arvalid, araddr, BASE);
    end
    vectors++;
    if ({arlen, arsize, arburst} !== {8'd3, 3'b010, 2'b01}) begin
      miscompares++;
      $display("FAIL ar_const got=%h/%h/%h want=3/2/1", arlen, arsize, arburst);
    end
    ar_block = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    ar_stall = 0;
    r_stall = 0;
    rdy_pct = 100;
    do_reset(1'b1);
    push_exp(BASE, 8);
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_drain left=%0d want=0", sb.size());
      sb.delete();
    end
    vectors++;
    if (ar_log.size() < 2 || ar_log[0] !== BASE) begin
      miscompares++;
      $display("FAIL basic_araddr got=%h want=%h", ar_log[0], BASE);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset(1'b1);
    tick(50);
    vectors++;
    if (ar_log.size() != 2) begin
      miscompares++;
      $display("FAIL bp_bursts got=%0d want=2", ar_log.size());
    end
    vectors++;
    if (arvalid !== 1'b0 || inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_idle got=%0b/%0b want=0/1", arvalid, inst_valid);
    end
    push_exp(BASE, 16);
    wait_drain(ok);
    vectors++;
    if (!ok || ar_log.size() < 4) begin
      miscompares++;
      $display("FAIL bp_resume left=%0d bursts=%0d want=0/>=4", sb.size(), ar_log.size());
      sb.delete();
    end
  endtask

  task automatic test_redirect_data;
    bit ok;
    int c = 0;
    do_reset(1'b1);
    while (!(rvalid && s_act && s_beat == 1) && c < 100) begin
      tick();
      c++;
    end
    vectors++;
    if (c >= 100) begin
      miscompares++;
      $display("FAIL rd_wait got=timeout want=beat1");
    end
    do_redirect(32'h4000_0108);
    push_exp(32'h4000_0108, 6);
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rd_drain left=%0d want=0", sb.size());
      sb.delete();
    end
    vectors++;
    if (ar_log.size() < 2 || ar_log[1] !== 32'h4000_0100) begin
      miscompares++;
      $display("FAIL rd_araddr got=%h want=40000100", ar_log[1]);
    end
  endtask

  task automatic test_redirect_addr;
    bit ok;
    int c = 0;
    ar_block = 1'b1;
    do_reset(1'b1);
    while (!arvalid && c < 20) begin
      tick();
      c++;
    end
    do_redirect(32'h4000_0208);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (arvalid !== 1'b1 || araddr !== BASE) begin
        miscompares++;
        $display("FAIL ra_hold got=%0b/%h want=1/%h", arvalid, araddr, BASE);
      end
      tick();
    end
    ar_block = 1'b0;
    push_exp(32'h4000_0208, 6);
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ra_drain left=%0d want=0", sb.size());
      sb.delete();
    end
    vectors++;
    if (ar_log.size() < 2 || ar_log[0] !== BASE ||
        ar_log[1] !== 32'h4000_0200) begin
      miscompares++;
      $display("FAIL ra_araddr got=%h,%h want=%h,40000200", ar_log[0], ar_log[1], BASE);
    end
  endtask

  task automatic test_slverr;
    bit ok;
    err_addr = BASE + 32'd8;
    do_reset(1'b1);
    push_exp(BASE, 8);
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL err_drain left=%0d want=0", sb.size());
      sb.delete();
    end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_wrap;
    bit ok;
    ar_stall = 30;
    r_stall = 30;
    rdy_pct = 60;
    do_reset(1'b0);
    tick();
    do_redirect(32'hFFFF_FFF0);
    enable = 1'b1;
    push_exp(32'hFFFF_FFF0, 12);
    wait_drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wrap_drain left=%0d want=0", sb.size());
      sb.delete();
    end
    vectors++;
    if (ar_log.size() < 2 || ar_log[0] !== 32'hFFFF_FFF0 ||
        ar_log[1] !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_araddr got=%h,%h want=fffffff0,00000000", ar_log[0], ar_log[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_data();
    test_redirect_addr();
    test_slverr();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
